// File: rtl/transmisor_dac_if.sv
// Bus between a frame requester and the transmisor_dac serial DAC transmitter.
// Handshake: a request is taken on any rising edge where start=1 and the
// transmitter is free (busy=0, or the last cycle of the previous frame's window).
// Dato and modo are captured only on that edge.
// busy stays high until the next request can be taken, and done pulses for one
// cycle when the last data bit has been shifted out.
interface transmisor_dac_if;
  logic        start;
  logic [11:0] Dato;
  logic [1:0]  modo;
  logic        data_DAC;
  logic        CS;
  logic        busy;
  logic        done;

  modport master (
    output start, Dato, modo,
    input  data_DAC, CS, busy, done
  );

  modport slave (
    input  start, Dato, modo,
    output data_DAC, CS, busy, done
  );
endinterface

// File: rtl/transmisor_dac.sv
// Serial transmitter for a 16-bit DAC frame {2'b00, modo, Dato}, MSB first,
// with CS low for exactly the 16 data bits and a programmable CS-high gap.
module transmisor_dac #(
  parameter int GAP_CYCLES = 1
) (
  input  logic               Clock_Muestreo,
  input  logic               reset,
  transmisor_dac_if.slave    bus,
  output logic [1:0]         estado_dbg
);

  typedef enum logic [1:0] {
    INICIO     = 2'd0,
    TRANSMITIR = 2'd1,
    FIN        = 2'd2,
    ESPERA     = 2'd3
  } estado_t;

  localparam logic [3:0] GAP_ULTIMO = 4'(GAP_CYCLES - 1);

  estado_t     estado_q, estado_d;
  logic [15:0] trama_q, trama_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  gap_q, gap_d;
  logic        cs_q, cs_d;
  logic        data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        libre;
  logic [15:0] trama_nueva;

  assign trama_nueva = {2'b00, bus.modo, bus.Dato};

  always_comb begin
    estado_d = estado_q;
    trama_d  = trama_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    cs_d     = cs_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    libre    = 1'b0;

    case (estado_q)
      INICIO: begin
        libre = 1'b1;
      end

      TRANSMITIR: begin
        if (bit_q == 4'd15) begin
          estado_d = FIN;
          cs_d     = 1'b1;
          data_d   = 1'b0;
          done_d   = 1'b1;
          trama_d  = '0;
          bit_d    = '0;
        end else begin
          trama_d = {trama_q[14:0], 1'b0};
          bit_d   = bit_q + 4'd1;
          data_d  = trama_q[14];
        end
      end

      FIN: begin
        if (GAP_CYCLES == 0) begin
          libre = 1'b1;
        end else begin
          estado_d = ESPERA;
          gap_d    = '0;
        end
      end

      ESPERA: begin
        if (gap_q == GAP_ULTIMO) begin
          libre = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: begin
        estado_d = INICIO;
        cs_d     = 1'b1;
        data_d   = 1'b0;
        busy_d   = 1'b0;
        trama_d  = '0;
        bit_d    = '0;
        gap_d    = '0;
      end
    endcase

    // The closing edge of a frame window doubles as the acceptance edge, which
    // gives back-to-back frames a period of 17+GAP_CYCLES cycles.
    if (libre) begin
      if (bus.start) begin
        estado_d = TRANSMITIR;
        trama_d  = trama_nueva;
        bit_d    = '0;
        gap_d    = '0;
        cs_d     = 1'b0;
        data_d   = trama_nueva[15];
        busy_d   = 1'b1;
      end else begin
        estado_d = INICIO;
        gap_d    = '0;
        cs_d     = 1'b1;
        data_d   = 1'b0;
        busy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock_Muestreo or posedge reset) begin
    if (reset) begin
      estado_q <= INICIO;
      trama_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      cs_q     <= 1'b1;
      data_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      trama_q  <= trama_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      cs_q     <= cs_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.CS       = cs_q;
  assign bus.data_DAC = data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign estado_dbg   = estado_q;

endmodule

// File: tb/tb_transmisor_dac.sv
// Bench for transmisor_dac: one instance with GAP_CYCLES=1 and one with 0,
// both driven from the same stimulus and compared against a frame-phase model.
module tb_transmisor_dac;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] dato;
  logic [1:0]  modo;
  logic [1:0]  dbg1, dbg0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  transmisor_dac_if if1 ();
  transmisor_dac_if if0 ();

  assign if1.start = start;
  assign if1.Dato  = dato;
  assign if1.modo  = modo;
  assign if0.start = start;
  assign if0.Dato  = dato;
  assign if0.modo  = modo;

  transmisor_dac #(.GAP_CYCLES(1)) dut1 (
    .Clock_Muestreo (clk),
    .reset          (rst),
    .bus            (if1.slave),
    .estado_dbg     (dbg1)
  );

  transmisor_dac #(.GAP_CYCLES(0)) dut0 (
    .Clock_Muestreo (clk),
    .reset          (rst),
    .bus            (if0.slave),
    .estado_dbg     (dbg0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: index 0 is the GAP_CYCLES=1 instance, index 1 the GAP_CYCLES=0 one.
  // A frame occupies phases 0..15 (data), 16 (done), then the gap phases.
  int          gap_of [2] = '{1, 0};
  bit          m_act [2];
  int          m_ph  [2];
  logic [15:0] m_fr  [2];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  bit          acepta;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0;
        m_ph[i]  = 0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        acepta = 1'b0;
        if (!m_act[i]) begin
          acepta = start;
        end else if (m_ph[i] == 16 + gap_of[i]) begin
          acepta = start;
          if (!start) m_act[i] = 1'b0;
        end else begin
          m_ph[i]++;
        end
        if (acepta) begin
          m_act[i] = 1'b1;
          m_ph[i]  = 0;
          m_fr[i]  = {2'b00, modo, dato};
          if (i == 0) exp_q0.push_back(m_fr[i]);
          else        exp_q1.push_back(m_fr[i]);
        end
      end
    end
  end

  // Output checker and frame monitor, sampled on the falling edge.
  logic [15:0] rx    [2];
  int          ncs   [2];
  int          done_cnt [2];
  logic        cs_prev [2];
  int          cyc_n = 0;
  int          falls1 [$];
  int          falls0 [$];
  logic [15:0] rx_log1 [$];
  logic [15:0] got_fr;
  logic [3:0]  obs_o, exp_o;
  logic        cs_now, d_now, dn_now;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx[i] = '0; ncs[i] = 0; done_cnt[i] = 0; cs_prev[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    for (int i = 0; i < 2; i++) begin
      obs_o = (i == 0) ? {if1.CS, if1.data_DAC, if1.busy, if1.done}
                       : {if0.CS, if0.data_DAC, if0.busy, if0.done};
      if (!m_act[i])        exp_o = 4'b1000;
      else if (m_ph[i] < 16) exp_o = {1'b0, m_fr[i][15 - m_ph[i]], 2'b10};
      else if (m_ph[i] == 16) exp_o = 4'b1011;
      else                    exp_o = 4'b1010;
      check_eq((i == 0) ? "outs_gap1" : "outs_gap0", {28'd0, obs_o}, {28'd0, exp_o});

      cs_now = obs_o[3];
      d_now  = obs_o[2];
      dn_now = obs_o[0];
      if (rst) begin
        rx[i]  = '0;
        ncs[i] = 0;
      end else begin
        if (cs_prev[i] && !cs_now) begin
          if (i == 0) falls1.push_back(cyc_n);
          else        falls0.push_back(cyc_n);
        end
        if (!cs_now) begin
          rx[i] = {rx[i][14:0], d_now};
          ncs[i]++;
        end else if (ncs[i] != 0) begin
          check_eq("cs_low_len", ncs[i], 16);
          if (i == 0) begin
            check_eq("frame_avail1", {31'd0, exp_q0.size() > 0}, 1);
            if (exp_q0.size() > 0) begin
              got_fr = exp_q0.pop_front();
              check_eq("frame_gap1", {16'd0, rx[i]}, {16'd0, got_fr});
            end
            rx_log1.push_back(rx[i]);
          end else begin
            check_eq("frame_avail0", {31'd0, exp_q1.size() > 0}, 1);
            if (exp_q1.size() > 0) begin
              got_fr = exp_q1.pop_front();
              check_eq("frame_gap0", {16'd0, rx[i]}, {16'd0, got_fr});
            end
          end
          ncs[i] = 0;
        end
        if (dn_now) done_cnt[i]++;
      end
      cs_prev[i] = cs_now;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a falling edge: reset lands mid low-phase and is checked before any clock edge.
  task automatic do_reset_mid();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_async_g1", {28'd0, if1.CS, if1.data_DAC, if1.busy, if1.done}, 32'h8);
    check_eq("rst_async_g0", {28'd0, if0.CS, if0.data_DAC, if0.busy, if0.done}, 32'h8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  int          snap;
  logic [15:0] want;
  bit          hold;

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    dato  = '0;
    modo  = '0;
    #1 rst = 1'b1;
    cyc(2);
    check_eq("rst_state_g1", {30'd0, dbg1}, 0);
    check_eq("rst_state_g0", {30'd0, dbg0}, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    rst   = 1'b0;
    cyc(2);

    // Single frame 0x1A5C, done at E16, busy low after E18 (model-checked per cycle).
    rx_log1.delete();
    snap = done_cnt[0];
    dato = 12'hA5C; modo = 2'b01;
    pulse_start();
    dato = 12'h123; modo = 2'b10;
    cyc(22);
    check_eq("f_a5c", {16'd0, (rx_log1.size() > 0) ? rx_log1[0] : 16'hDEAD}, 32'h1A5C);
    check_eq("f_a5c_done", done_cnt[0] - snap, 1);

    // All-zero data with modo=11.
    rx_log1.delete();
    dato = 12'h000; modo = 2'b11;
    pulse_start();
    cyc(22);
    check_eq("f_3000", {16'd0, (rx_log1.size() > 0) ? rx_log1[0] : 16'hDEAD}, 32'h3000);

    // start held high, Dato changed mid-frame.
    rx_log1.delete();
    falls1.delete();
    falls0.delete();
    dato = 12'hFFF; modo = 2'b00;
    start = 1'b1;
    cyc(6);
    dato = 12'h001;
    cyc(34);
    start = 1'b0;
    cyc(40);
    check_eq("held_f0", {16'd0, (rx_log1.size() > 0) ? rx_log1[0] : 16'hDEAD}, 32'h0FFF);
    check_eq("held_f1", {16'd0, (rx_log1.size() > 1) ? rx_log1[1] : 16'hDEAD}, 32'h0001);
    check_eq("period_g1", (falls1.size() > 1) ? falls1[1] - falls1[0] : 0, 18);
    check_eq("period_g0", (falls0.size() > 1) ? falls0[1] - falls0[0] : 0, 17);

    // start re-pulsed at E3 and E17 (FIN of the GAP=1 instance) is ignored there.
    snap = done_cnt[0];
    rx_log1.delete();
    dato = 12'h5A3; modo = 2'b10;
    pulse_start();
    cyc(2);
    pulse_start();
    cyc(13);
    pulse_start();
    cyc(25);
    check_eq("ignore_done", done_cnt[0] - snap, 1);
    check_eq("ignore_frames", rx_log1.size(), 1);

    // Reset after E7 aborts the frame with no done pulse, then a fresh frame.
    snap = done_cnt[0];
    dato = 12'h777; modo = 2'b01;
    pulse_start();
    cyc(7);
    do_reset_mid();
    cyc(3);
    check_eq("abort_no_done", done_cnt[0] - snap, 0);
    rx_log1.delete();
    dato = 12'($urandom); modo = 2'($urandom);
    want = {2'b00, modo, dato};
    pulse_start();
    cyc(22);
    check_eq("post_rst_frame", {16'd0, (rx_log1.size() > 0) ? rx_log1[0] : 16'hDEAD}, {16'd0, want});
    check_eq("post_rst_done", done_cnt[0] - snap, 1);

    // Random traffic with input churn and occasional resets.
    hold = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      dato = 12'($urandom);
      modo = 2'($urandom);
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      start = hold ? 1'b1 : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) do_reset_mid();
      else cyc(1);
    end
    start = 1'b0;
    cyc(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
